// File: rtl/debounce4_if.sv
// Pin-side bundle for the four-channel debouncer: raw levels in, clean levels and
// edge pulses out. The master drives the raw pins; the slave is the debouncer.
interface debounce4_if;
   logic x0, x1, x2, x3;
   logic z0, z1, z2, z3;
   logic r0, r1, r2, r3;
   logic f0, f1, f2, f3;

   modport master (
      output x0, x1, x2, x3,
      input  z0, z1, z2, z3,
      input  r0, r1, r2, r3,
      input  f0, f1, f2, f3
   );

   modport slave (
      input  x0, x1, x2, x3,
      output z0, z1, z2, z3,
      output r0, r1, r2, r3,
      output f0, f1, f2, f3
   );
endinterface

// File: rtl/debounce4.sv
// Four independent channels, each: two-flop synchronizer, a mismatch counter that
// promotes the synchronized level to the stable level after DEBOUNCE_CYCLES
// consecutive mismatching cycles, and registered one-cycle rise/fall pulses.
module debounce4 #(
   parameter int unsigned DEBOUNCE_CYCLES = 120000,
   parameter int unsigned CNT_W           = 17
) (
   input logic        clk,
   input logic        rst,
   debounce4_if.slave bus
);

   // Terminal count: the edge that sees this value with a mismatch commits the level.
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       w_x;
   logic [3:0]       r_s1;
   logic [3:0]       r_s2;
   logic [3:0]       r_z;
   logic [3:0]       r_rise;
   logic [3:0]       r_fall;
   logic [CNT_W-1:0] r_cnt [4];

   assign w_x = {bus.x3, bus.x2, bus.x1, bus.x0};

   // Two-stage synchronizer for the asynchronous pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= w_x;
         r_s2 <= r_s1;
      end
   end

   // Per-channel debounce: any matching cycle clears the count, so bounce restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_z    <= '0;
         r_rise <= '0;
         r_fall <= '0;
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_rise[i] <= 1'b0;
            r_fall[i] <= 1'b0;
            if (r_s2[i] == r_z[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == LP_LAST) begin
               r_z[i]    <= r_s2[i];
               r_cnt[i]  <= '0;
               r_rise[i] <= r_s2[i];
               r_fall[i] <= ~r_s2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign bus.z0 = r_z[0];
   assign bus.z1 = r_z[1];
   assign bus.z2 = r_z[2];
   assign bus.z3 = r_z[3];
   assign bus.r0 = r_rise[0];
   assign bus.r1 = r_rise[1];
   assign bus.r2 = r_rise[2];
   assign bus.r3 = r_rise[3];
   assign bus.f0 = r_fall[0];
   assign bus.f1 = r_fall[1];
   assign bus.f2 = r_fall[2];
   assign bus.f3 = r_fall[3];

endmodule

// File: tb/tb_debounce4.sv
// Directed bench for debounce4 with DEBOUNCE_CYCLES=4, CNT_W=3. Outputs are compared
// as one 12-bit word {z3..z0, r3..r0, f3..f0} sampled 1 time unit after each rising edge.
module tb_debounce4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   debounce4_if bus ();

   debounce4 #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] outs();
      return {bus.z3, bus.z2, bus.z1, bus.z0,
              bus.r3, bus.r2, bus.r1, bus.r0,
              bus.f3, bus.f2, bus.f1, bus.f0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got zrf=%b expected zrf=%b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic run(input int n, input logic [11:0] exp, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         check(tag, outs(), exp);
      end
   endtask

   task automatic set_x(input logic [3:0] v);
      bus.x0 = v[0];
      bus.x1 = v[1];
      bus.x2 = v[2];
      bus.x3 = v[3];
   endtask

   logic pat [8];

   initial begin
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset held with all pins high: nothing may propagate.
      set_x(4'hF);
      run(10, 12'b0000_0000_0000, "rst_hold");
      set_x(4'h0);
      tick();
      rst = 1'b0;
      run(2, 12'b0000_0000_0000, "idle");

      // Clean press on x0: first sampled at the next edge k, commits at k+5.
      bus.x0 = 1'b1;
      run(5, 12'b0000_0000_0000, "press_wait");
      run(1, 12'b0001_0001_0000, "press_edge");
      run(1, 12'b0001_0000_0000, "press_hold");

      // Three-cycle glitch on x1 reaches the terminal count but never commits.
      bus.x1 = 1'b1;
      run(3, 12'b0001_0000_0000, "glitch_hi");
      bus.x1 = 1'b0;
      run(8, 12'b0001_0000_0000, "glitch_lo");

      // Bounce on x2: the single 0 restarts the count; final 0->1 sample is edge 5.
      for (int m = 0; m < 8; m++) begin
         bus.x2 = pat[m];
         tick();
         check("bounce", outs(), 12'b0001_0000_0000);
      end
      run(1, 12'b0001_0000_0000, "bounce_wait");
      run(1, 12'b0101_0100_0000, "bounce_edge");
      run(1, 12'b0101_0000_0000, "bounce_hold");

      // Bring z3 up so that channels 0 and 3 can be released together.
      bus.x3 = 1'b1;
      run(5, 12'b0101_0000_0000, "z3_wait");
      run(1, 12'b1101_1000_0000, "z3_edge");
      run(1, 12'b1101_0000_0000, "z3_hold");

      // Simultaneous release of x0 and x3.
      bus.x0 = 1'b0;
      bus.x3 = 1'b0;
      run(5, 12'b1101_0000_0000, "rel_wait");
      run(1, 12'b0100_0000_1001, "rel_edge");
      run(1, 12'b0100_0000_0000, "rel_hold");

      // Reset mid-count on x1, asserted between edges while z2 is high.
      bus.x1 = 1'b1;
      run(3, 12'b0100_0000_0000, "mid_count");
      #2;
      rst = 1'b1;
      #1;
      check("rst_async", outs(), 12'b0000_0000_0000);
      run(1, 12'b0000_0000_0000, "rst_edge");
      rst = 1'b0;

      // x1 and x2 are still high: both rise after the full latency from release.
      run(5, 12'b0000_0000_0000, "post_rst_wait");
      run(1, 12'b0110_0110_0000, "post_rst_edge");
      run(1, 12'b0110_0000_0000, "post_rst_hold");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
